// File: rtl/slug_pkg.sv
// Shared types and constants for the slug RAM arbiter slice.
package slug_pkg;

    typedef enum logic {
        ARB_CPU,
        ARB_FORCE
    } arb_state_t;

    localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT; clr has priority over inc.
module sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/slug_ram_arbiter.sv
// Shares the single-port data RAM between the slug CPU (fixed priority) and the host port,
// with a starvation counter that forces one host access after STARVE denied cycles.
module slug_ram_arbiter
    import slug_pkg::*;
#(
    parameter int DW     = 4,
    parameter int AW     = 16,
    parameter int STARVE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_stall,
    output logic [DW-1:0]          cpu_rdata,
    input  logic                   host_valid,
    input  logic                   host_we,
    input  logic [AW-1:0]          host_addr,
    input  logic [DW-1:0]          host_wdata,
    output logic                   host_ready,
    output logic                   host_rvalid,
    output logic [DW-1:0]          host_rdata,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   ram_re,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_a,
    output logic [DW-1:0]          ram_x,
    input  logic [DW-1:0]          ram_y
);

    localparam logic [3:0] WAIT_TRIP = 4'(STARVE - 1);

    arb_state_t state, state_next;
    logic [3:0] wait_cnt;
    logic       cpu_win, host_win;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (!rst) begin
            if (state == ARB_FORCE) begin
                host_win = host_valid;
            end else begin
                cpu_win  = cpu_req;
                host_win = host_valid & ~cpu_req;
            end
        end
    end

    // A denied host with wait_cnt at STARVE-1 means the counter reaches STARVE at this edge.
    always_comb begin
        state_next = state;
        case (state)
            ARB_CPU:   if (host_valid && !host_win && wait_cnt >= WAIT_TRIP) state_next = ARB_FORCE;
            ARB_FORCE: if (host_win || !host_valid) state_next = ARB_CPU;
            default:   state_next = ARB_CPU;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_CPU;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        ram_re = 1'b0;
        ram_we = 1'b0;
        ram_a  = '0;
        ram_x  = '0;
        if (cpu_win) begin
            ram_we = cpu_we;
            ram_re = ~cpu_we;
            ram_a  = cpu_addr;
            ram_x  = cpu_wdata;
        end else if (host_win) begin
            ram_we = host_we;
            ram_re = ~host_we;
            ram_a  = host_addr;
            ram_x  = host_wdata;
        end
    end

    assign cpu_gnt    = cpu_win;
    assign host_ready = host_win;
    assign cpu_stall  = cpu_req & ~cpu_win;
    assign cpu_rdata  = ram_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_win & ~host_we;
            if (host_win && !host_we) host_rdata <= ram_y;
        end
    end

    sat_counter #(.W(4), .LIMIT(STARVE)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~host_valid | host_win),
        .inc (1'b1),
        .cnt (wait_cnt)
    );

    sat_counter #(.W(STALL_CNT_W), .LIMIT((1 << STALL_CNT_W) - 1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (cpu_stall),
        .cnt (stall_count)
    );

endmodule

// File: tb/tb_slug_ram_arbiter.sv
// Self-checking bench for slug_ram_arbiter: directed scenarios plus random traffic
// checked against a rule-level model of priority, starvation and RAM contents.
module tb_slug_ram_arbiter;

    localparam int DW     = 4;
    localparam int AW     = 16;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, host_valid, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;

    logic          cpu_gnt, cpu_stall, host_ready, host_rvalid, ram_re, ram_we;
    logic [DW-1:0] cpu_rdata, host_rdata, ram_x, ram_y;
    logic [AW-1:0] ram_a;
    logic [7:0]    stall_count;

    logic          s_cpu_gnt, s_cpu_stall, s_host_ready, s_host_rvalid, s_ram_re, s_ram_we;
    logic [DW-1:0] s_cpu_rdata, s_host_rdata, s_ram_x;
    logic [DW-1:0] s_ram_y = '0;
    logic [AW-1:0] s_ram_a;
    logic [7:0]    s_stall_count;

    logic [DW-1:0] mem   [0:65535];
    logic [DW-1:0] m_mem [0:65535];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_denied, m_stall;
    bit   m_rvalid;
    logic [DW-1:0] m_rdata;
    bit   e_cg, e_hr;
    logic o_cg, o_hr;
    logic [7:0] o_stall, o_s_stall;

    always #5 clk = ~clk;

    slug_ram_arbiter #(.DW(DW), .AW(AW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .stall_count(stall_count),
        .ram_re(ram_re), .ram_we(ram_we), .ram_a(ram_a), .ram_x(ram_x), .ram_y(ram_y)
    );

    // Second instance with STARVE = 1 shares the stimulus; only its stall counter is observed.
    slug_ram_arbiter #(.DW(DW), .AW(AW), .STARVE(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(s_cpu_gnt), .cpu_stall(s_cpu_stall), .cpu_rdata(s_cpu_rdata),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(s_host_ready), .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata),
        .stall_count(s_stall_count),
        .ram_re(s_ram_re), .ram_we(s_ram_we), .ram_a(s_ram_a), .ram_x(s_ram_x), .ram_y(s_ram_y)
    );

    assign ram_y = mem[ram_a];

    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_x;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit hv, input bit hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        cpu_req    = cr;
        cpu_we     = cw;
        cpu_addr   = ca;
        cpu_wdata  = cd;
        host_valid = hv;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
    endtask

    task automatic model_reset();
        m_denied = 0;
        m_stall  = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // One clock cycle: check everything at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit            forced, ere, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ex;
        @(negedge clk);
        forced = (m_denied >= STARVE);
        e_cg   = cpu_req && !forced;
        e_hr   = host_valid && (forced || !cpu_req);
        ere = 1'b0; ewe = 1'b0; ea = '0; ex = '0;
        if (e_cg) begin
            ewe = cpu_we; ere = !cpu_we; ea = cpu_addr; ex = cpu_wdata;
        end else if (e_hr) begin
            ewe = host_we; ere = !host_we; ea = host_addr; ex = host_wdata;
        end
        o_cg = cpu_gnt; o_hr = host_ready; o_stall = stall_count; o_s_stall = s_stall_count;
        chk("cpu_gnt",     32'(cpu_gnt),     32'(e_cg));
        chk("cpu_stall",   32'(cpu_stall),   32'(cpu_req && !e_cg));
        chk("host_ready",  32'(host_ready),  32'(e_hr));
        chk("ram_re",      32'(ram_re),      32'(ere));
        chk("ram_we",      32'(ram_we),      32'(ewe));
        chk("ram_a",       32'(ram_a),       32'(ea));
        chk("ram_x",       32'(ram_x),       32'(ex));
        chk("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
        chk("host_rdata",  32'(host_rdata),  32'(m_rdata));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        if (e_cg && !cpu_we) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_mem[cpu_addr]));
        @(posedge clk);
        m_rvalid = e_hr && !host_we;
        if (m_rvalid) m_rdata = m_mem[host_addr];
        if (ewe) m_mem[ea] = ex;
        if (cpu_req && !e_cg && m_stall < 255) m_stall++;
        m_denied = (host_valid && !e_hr) ? ((m_denied < STARVE) ? m_denied + 1 : STARVE) : 0;
        cyc++;
        #1;
    endtask

    initial begin
        bit            hp;
        bit            hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;

        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0010, 4'h0, 1'b1, 1'b0, 16'h0003, 4'h0);
        for (int i = 0; i < 65536; i++) begin
            mem[i]   <= '0;
            m_mem[i]  = '0;
        end
        mem[16]   <= 4'hA;
        m_mem[16]  = 4'hA;
        model_reset();
        #2;
        chk("rst_cpu_gnt",     32'(cpu_gnt),       32'd0);
        chk("rst_host_ready",  32'(host_ready),    32'd0);
        chk("rst_ram_re",      32'(ram_re),        32'd0);
        chk("rst_ram_we",      32'(ram_we),        32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid),   32'd0);
        chk("rst_stall_count", 32'(stall_count),   32'd0);
        chk("rst_s1_stall",    32'(s_stall_count), 32'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CPU-only read of a preloaded word.
        drive(1'b1, 1'b0, 16'h0010, 4'h0, 1'b0, 1'b0, '0, '0);
        step();
        chk("cpu_only_gnt",   32'(o_cg),      32'd1);
        chk("cpu_only_rdata", 32'(cpu_rdata), 32'hA);
        chk("cpu_only_stall", 32'(o_stall),   32'd0);

        // Host-only write then read back.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0003, 4'h5);
        step();
        chk("host_wr_ready", 32'(o_hr), 32'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0003, 4'h0);
        step();
        chk("host_rd_ready", 32'(o_hr),        32'd1);
        chk("host_rd_valid", 32'(host_rvalid), 32'd1);
        chk("host_rd_data",  32'(host_rdata),  32'h5);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step();
        chk("host_rvalid_pulse", 32'(host_rvalid), 32'd0);

        // Starvation: host denied 4 cycles, forced on the 5th, CPU back on the 6th.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 16'(k), '0, k <= 4, 1'b0, 16'h0003, '0);
            step();
            chk("starve_host_ready", 32'(o_hr), 32'(k == 4));
            chk("starve_cpu_gnt",    32'(o_cg), 32'(k != 4));
        end
        chk("starve_stall_count", 32'(o_stall), 32'd1);

        // Host drops valid while forced; the starvation window must restart from zero.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b1, 16'h0007, 4'h9);
            step();
        end
        drive(1'b1, 1'b0, 16'h0001, '0, 1'b0, 1'b1, 16'h0007, 4'h9);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b1, 16'h0007, 4'h9);
            step();
            chk("drop_host_ready", 32'(o_hr), 32'(k == 4));
            chk("drop_cpu_gnt",    32'(o_cg), 32'(k != 4));
        end

        // Reset right after a host read accept.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0007, '0);
        step();
        chk("pre_rst_accept", 32'(o_hr), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h0002, 4'h3, 1'b1, 1'b1, 16'h0004, 4'h4);
        #1;
        chk("mid_rst_rvalid",     32'(host_rvalid), 32'd0);
        chk("mid_rst_rdata",      32'(host_rdata),  32'd0);
        chk("mid_rst_cpu_gnt",    32'(cpu_gnt),     32'd0);
        chk("mid_rst_host_ready", 32'(host_ready),  32'd0);
        chk("mid_rst_ram_re",     32'(ram_re),      32'd0);
        chk("mid_rst_ram_we",     32'(ram_we),      32'd0);
        chk("mid_rst_stall",      32'(stall_count), 32'd0);
        @(negedge clk);
        chk("mid_rst_rvalid_hold", 32'(host_rvalid), 32'd0);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        step();
        chk("post_rst_cpu_gnt", 32'(o_cg), 32'd1);

        // Random traffic with a well-behaved host.
        hp = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hp && $urandom_range(0, 2) != 0) begin
                hp = 1'b1;
                hw = 1'($urandom_range(0, 1));
                ha = 16'($urandom_range(0, 15));
                hd = 4'($urandom_range(0, 15));
            end
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), hp, hw, ha, hd);
            step();
            if (e_hr) hp = 1'b0;
        end

        // Stall-counter saturation on the STARVE = 1 instance: one stall every other cycle.
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b0, 16'h0002, '0);
        for (int i = 0; i < 620; i++) begin
            step();
            chk("sat_stall_count", 32'(o_s_stall), 32'((i / 2 < 255) ? i / 2 : 255));
        end
        chk("sat_stall_final", 32'(s_stall_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slug_ram_arbiter.md
# slug_ram_arbiter

Two-requester arbiter that shares the single-port 4-bit data RAM between the slug CPU core and a host/debug port. The host port is used for loading data and inspecting state while the CPU runs. The CPU has fixed priority. A saturating starvation counter forces one host access after `STARVE` consecutive denied host cycles. The block sits between the CPU's RAM control signals (`reram`/`weram`/`addr`/`data`) and the `ram` instance, and exports a stall indication the CPU sequencer uses to hold its program counter.

## Interface
Parameters:
- `DW`, default 4: data width (RAM word).
- `AW`, default 16: address width.
- `STARVE`, default 4: number of consecutive denied host cycles before a forced host grant; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `cpu_req`, in, 1: CPU requests the RAM this cycle (`reram | weram`).
- `cpu_we`, in, 1: CPU write (1) or read (0).
- `cpu_addr`, in, AW: CPU address.
- `cpu_wdata`, in, DW: CPU write data.
- `cpu_gnt`, out, 1: CPU access performed this cycle.
- `cpu_stall`, out, 1: `cpu_req & ~cpu_gnt`; the CPU holds its PC and controls.
- `cpu_rdata`, out, DW: RAM read data, combinational, valid when `cpu_gnt & ~cpu_we`.
- `host_valid`, in, 1: host request pending; must stay high with stable fields until accepted.
- `host_we`, in, 1: host write/read.
- `host_addr`, in, AW: host address.
- `host_wdata`, in, DW: host write data.
- `host_ready`, out, 1: host request accepted this cycle.
- `host_rvalid`, out, 1: one-cycle pulse, host read data valid.
- `host_rdata`, out, DW: registered host read data.
- `stall_count`, out, 8: saturating count of `cpu_stall` cycles since reset.
- `ram_re`, out, 1; `ram_we`, out, 1; `ram_a`, out, AW; `ram_x`, out, DW: RAM controls.
- `ram_y`, in, DW: RAM read data (asynchronous read).

## Operation
- The FSM has 2 states:
  - `ARB_CPU` (reset state): the CPU wins whenever `cpu_req` is high; the host wins only when `cpu_req` is low.
  - `ARB_FORCE`: the host wins whenever `host_valid` is high; the CPU is denied (`cpu_stall` = `cpu_req`).
- `wait_cnt` (4 bits):
  - Cleared when `host_valid` is low or the host is accepted.
  - Otherwise incremented, saturating at `STARVE`.
- Transitions:
  - `ARB_CPU` → `ARB_FORCE` at the edge where the next `wait_cnt` equals `STARVE`.
  - `ARB_FORCE` → `ARB_CPU` on host accept, or if `host_valid` drops (protocol violation, tolerated); `wait_cnt` is cleared.
- RAM muxing:
  - The winner drives `ram_a`, `ram_x`, and `ram_we` = winner's `we`, `ram_re` = ~`we`.
  - With no winner, `ram_re` = `ram_we` = 0 and `ram_a`/`ram_x` = 0.
- Host read: on accept with `host_we` = 0, `host_rdata` <= `ram_y` and `host_rvalid` <= 1 for exactly one cycle. Host writes produce no `host_rvalid`.
- A host write and a CPU read of the same address in adjacent cycles are ordered by grant order; the arbiter adds no forwarding.
- `stall_count` increments on every cycle with `cpu_stall` high and holds at 255.

## Timing
- Grants are combinational within the cycle: `cpu_gnt`, `host_ready` and the RAM controls depend on the current-cycle requests plus registered state.
- CPU access latency is 0 cycles when granted. Host read data arrives 1 cycle after `host_ready`.
- Worst-case host wait with the CPU requesting continuously: `STARVE` denied cycles, then accepted on cycle `STARVE`+1.
- In a single cycle, `cpu_gnt` and `host_ready` are never both high.
- `rst` asserted, asynchronous, at any time including mid-access:
  - Registered state is cleared: state = `ARB_CPU`, `wait_cnt` = 0, `host_rvalid` = 0, `host_rdata` = 0, `stall_count` = 0.
  - `cpu_gnt`, `host_ready`, `ram_re` and `ram_we` are forced to 0 while `rst` is high.
  - A host read accepted in the cycle before reset produces no `host_rvalid`.
- `ram_we` is only asserted in a cycle with exactly one grant. The write commits at the following edge.

## Structure
- Package `slug_pkg`: `arb_state_t` enum {`ARB_CPU`, `ARB_FORCE`} and the constant `STALL_CNT_W` = 8.
- Sub-module `sat_counter` (parameterised width and limit, with `clr` and `inc`) is used for both `wait_cnt` and `stall_count`.
- The arbiter FSM and muxing stay in the top module.

## Test plan
- CPU only: `cpu_req` read of addr 0x0010 holding 0xA → `cpu_gnt` = 1 in the same cycle, `cpu_rdata` = 0xA, `stall_count` stays 0.
- Host only: host write 0x5 to 0x0003, then host read of 0x0003 → `host_ready` in each request cycle, `host_rvalid` 1 cycle after the read accept, `host_rdata` = 0x5.
- Starvation with `STARVE` = 4: `cpu_req` held high and `host_valid` high from cycle 0 → host denied cycles 0–3, `host_ready` and `cpu_stall` in cycle 4, `cpu_gnt` back in cycle 5, `stall_count` = 1.
- Simultaneous requests in `ARB_CPU` with `wait_cnt` = 0 → CPU granted, the host waits. Host drops `host_valid` in `ARB_FORCE` → return to `ARB_CPU`, `wait_cnt` = 0.
- Reset mid-read: assert `rst` in the cycle after a host read accept → `host_rvalid` never pulses and all outputs are 0. After release, the first CPU request is granted immediately.
- `stall_count` saturation: force 300 stall cycles with `STARVE` = 1 → `stall_count` holds at 255.
